hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB). Each cycle it decides stalls, bubbles, flushes and EX-stage forwarding selects from stage register-address and control fields. It also freezes the pipeline during multi-cycle data-memory accesses and inserts the extra fetch bubble required by the synchronous instruction memory after a redirect. It keeps saturating performance counters for stall cycles and redirects.

---
 rtl/hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_ctrl_if.sv | 33 +++
 rtl/hazard_ctrl_fwd_unit.sv | 18 +
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_REDIR    = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MEM result is younger than WB, so it wins; x0 is hardwired zero and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] mem_rd, input logic mem_we,
                                         input logic [4:0] wb_rd,  input logic wb_we);
    if (mem_we && mem_rd != 5'd0 && mem_rd == rs) return FWD_MEM;
    if (wb_we && wb_rd != 5'd0 && wb_rd == rs)    return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - stage fields in, pipeline controls and counters out
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1, id_rs2;
  logic             id_use_rs1, id_use_rs2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_memread, ex_regwrite;
  logic [4:0]       mem_rd;
  logic             mem_regwrite;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic             ex_redirect;
  logic             dmem_req, dmem_ready;
  logic             pc_we, ifid_we, idex_we, exmem_we;
  logic             ifid_flush, idex_flush, memwb_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles, redirects;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_memread, ex_regwrite, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
           ex_redirect, dmem_req, dmem_ready,
    input  pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush,
           fwd_a, fwd_b, stall_cycles, redirects
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
           ex_memread, ex_regwrite, mem_rd, mem_regwrite, wb_rd, wb_regwrite,
           ex_redirect, dmem_req, dmem_ready,
    output pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_flush, memwb_flush,
           fwd_a, fwd_b, stall_cycles, redirects
  );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// rtl/hazard_ctrl_fwd_unit.sv - combinational EX operand forwarding compare
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [4:0] wb_rd,
  input  logic       wb_regwrite,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencing for the 5-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  state_e           state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [1:0]       fwd_a_raw, fwd_b_raw;
  logic             load_use, frozen, redir_take;

  hazard_ctrl_fwd_unit u_fwd (
    .ex_rs1      (hz.ex_rs1),
    .ex_rs2      (hz.ex_rs2),
    .mem_rd      (hz.mem_rd),
    .mem_regwrite(hz.mem_regwrite),
    .wb_rd       (hz.wb_rd),
    .wb_regwrite (hz.wb_regwrite),
    .fwd_a       (fwd_a_raw),
    .fwd_b       (fwd_b_raw)
  );

  assign load_use = hz.ex_memread && hz.ex_rd != 5'd0 &&
                    ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                     (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

  // In MEM_WAIT the freeze is held purely by dmem_ready; elsewhere by a fresh miss.
  assign frozen = (state_q == ST_MEM_WAIT) ? !hz.dmem_ready
                                           : (hz.dmem_req && !hz.dmem_ready);
  assign redir_take = !rst && !frozen && hz.ex_redirect;

  always_comb begin
    hz.pc_we       = 1'b1;
    hz.ifid_we     = 1'b1;
    hz.idex_we     = 1'b1;
    hz.exmem_we    = 1'b1;
    hz.ifid_flush  = 1'b0;
    hz.idex_flush  = 1'b0;
    hz.memwb_flush = 1'b0;
    hz.fwd_a       = rst ? FWD_RF : fwd_a_raw;
    hz.fwd_b       = rst ? FWD_RF : fwd_b_raw;
    state_d        = ST_RUN;
    redir_pend_d   = 1'b0;

    if (rst) begin
      {hz.pc_we, hz.ifid_we, hz.idex_we, hz.exmem_we} = 4'b0000;
      {hz.ifid_flush, hz.idex_flush, hz.memwb_flush}  = 3'b111;
    end else if (frozen) begin
      {hz.pc_we, hz.ifid_we, hz.idex_we, hz.exmem_we} = 4'b0000;
      hz.memwb_flush = 1'b1;
      state_d        = ST_MEM_WAIT;
      redir_pend_d   = redir_pend_q || (state_q == ST_REDIR);
    end else begin
      if (hz.ex_redirect) begin
        hz.ifid_flush = 1'b1;
        hz.idex_flush = 1'b1;
        state_d       = ST_REDIR;
      end else if (load_use) begin
        hz.pc_we      = 1'b0;
        hz.ifid_we    = 1'b0;
        hz.idex_flush = 1'b1;
      end
      // The fetch issued alongside the redirect is still in flight; drop it.
      if (state_q == ST_REDIR || (state_q == ST_MEM_WAIT && redir_pend_q))
        hz.ifid_flush = 1'b1;
    end

    stall_d     = stall_q;
    redir_cnt_d = redir_cnt_q;
    if (!rst && !hz.pc_we && !(&stall_q)) stall_d = stall_q + 1'b1;
    if (redir_take && !(&redir_cnt_q))    redir_cnt_d = redir_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      redir_pend_q <= 1'b0;
      stall_q      <= '0;
      redir_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      stall_q      <= stall_d;
      redir_cnt_q  <= redir_cnt_d;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.redirects    = redir_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) hif ();
  hazard_ctrl_if #(.CNT_W(4))  sif ();

  hazard_ctrl #(.CNT_W(32)) dut     (.clk(clk), .rst(rst),  .hz(hif));
  hazard_ctrl #(.CNT_W(4))  dut_sat (.clk(clk), .rst(srst), .hz(sif));

  typedef struct {
    string      nm;
    logic [10:0] ctl;
    int          sc;
    int          rc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [10:0] act;
  int vectors = 0;
  int miscompares = 0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      act = {hif.pc_we, hif.ifid_we, hif.idex_we, hif.exmem_we,
             hif.ifid_flush, hif.idex_flush, hif.memwb_flush, hif.fwd_a, hif.fwd_b};
      if (act !== e.ctl) begin
        miscompares++;
        $display("FAIL %s: en/fl/fa/fb got %b_%b_%b_%b want %b_%b_%b_%b", e.nm,
                 act[10:7], act[6:4], act[3:2], act[1:0],
                 e.ctl[10:7], e.ctl[6:4], e.ctl[3:2], e.ctl[1:0]);
      end
      if (e.sc >= 0 && hif.stall_cycles !== 32'(e.sc)) begin
        miscompares++;
        $display("FAIL %s stall_cycles: got %0d want %0d", e.nm, hif.stall_cycles, e.sc);
      end
      if (e.rc >= 0 && hif.redirects !== 32'(e.rc)) begin
        miscompares++;
        $display("FAIL %s redirects: got %0d want %0d", e.nm, hif.redirects, e.rc);
      end
    end
  end

  task automatic clr();
    hif.id_rs1 = 5'd0; hif.id_rs2 = 5'd0; hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
    hif.ex_rs1 = 5'd0; hif.ex_rs2 = 5'd0; hif.ex_rd = 5'd0;
    hif.ex_memread = 1'b0; hif.ex_regwrite = 1'b0;
    hif.mem_rd = 5'd0; hif.mem_regwrite = 1'b0; hif.wb_rd = 5'd0; hif.wb_regwrite = 1'b0;
    hif.ex_redirect = 1'b0; hif.dmem_req = 1'b0; hif.dmem_ready = 1'b0;
  endtask

  task automatic step(input string nm, input logic [3:0] en, input logic [2:0] fl,
                      input logic [1:0] fa, input logic [1:0] fb, input int sc, input int rc);
    exp_t x;
    x.nm = nm; x.ctl = {en, fl, fa, fb}; x.sc = sc; x.rc = rc;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    sif.id_rs1 = 5'd0; sif.id_rs2 = 5'd0; sif.id_use_rs1 = 1'b0; sif.id_use_rs2 = 1'b0;
    sif.ex_rs1 = 5'd0; sif.ex_rs2 = 5'd0; sif.ex_rd = 5'd0;
    sif.ex_memread = 1'b0; sif.ex_regwrite = 1'b0;
    sif.mem_rd = 5'd0; sif.mem_regwrite = 1'b0; sif.wb_rd = 5'd0; sif.wb_regwrite = 1'b0;
    sif.ex_redirect = 1'b0; sif.dmem_req = 1'b1; sif.dmem_ready = 1'b0;
    @(posedge clk);
    #1;

    step("reset0", 4'b0000, 3'b111, 2'b00, 2'b00, -1, -1);
    step("reset1", 4'b0000, 3'b111, 2'b00, 2'b00, 0, 0);
    rst = 1'b0; srst = 1'b0;
    step("idle", 4'b1111, 3'b000, 2'b00, 2'b00, 0, 0);

    hif.ex_rs1 = 5'd5; hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
    hif.wb_rd = 5'd5; hif.wb_regwrite = 1'b1;
    step("fwd_mem_prio", 4'b1111, 3'b000, 2'b10, 2'b00, 0, 0);
    clr(); hif.ex_rs1 = 5'd3; hif.ex_rs2 = 5'd3; hif.wb_rd = 5'd3; hif.wb_regwrite = 1'b1;
    hif.mem_rd = 5'd4; hif.mem_regwrite = 1'b1;
    step("fwd_wb", 4'b1111, 3'b000, 2'b01, 2'b01, 0, 0);
    clr(); hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
    step("fwd_x0", 4'b1111, 3'b000, 2'b00, 2'b00, 0, 0);
    clr(); hif.ex_rs2 = 5'd9; hif.mem_rd = 5'd9; hif.wb_rd = 5'd9; hif.wb_regwrite = 1'b1;
    step("fwd_mem_nowe", 4'b1111, 3'b000, 2'b00, 2'b01, 0, 0);

    clr(); hif.ex_memread = 1'b1; hif.ex_rd = 5'd7; hif.id_rs2 = 5'd7;
    step("lu_unused_rs2", 4'b1111, 3'b000, 2'b00, 2'b00, 0, 0);
    hif.id_use_rs2 = 1'b1;
    step("lu_stall", 4'b0011, 3'b010, 2'b00, 2'b00, 0, 0);
    clr();
    step("lu_after", 4'b1111, 3'b000, 2'b00, 2'b00, 1, 0);
    hif.ex_memread = 1'b1; hif.id_use_rs1 = 1'b1;
    step("lu_rd_x0", 4'b1111, 3'b000, 2'b00, 2'b00, 1, 0);

    clr(); hif.ex_redirect = 1'b1;
    step("redir_flush", 4'b1111, 3'b110, 2'b00, 2'b00, 1, 0);
    clr();
    step("redir_state", 4'b1111, 3'b100, 2'b00, 2'b00, 1, 1);
    step("redir_run", 4'b1111, 3'b000, 2'b00, 2'b00, 1, 1);

    hif.dmem_req = 1'b1;
    step("mw_0", 4'b0000, 3'b001, 2'b00, 2'b00, 1, 1);
    step("mw_1", 4'b0000, 3'b001, 2'b00, 2'b00, 2, 1);
    step("mw_2", 4'b0000, 3'b001, 2'b00, 2'b00, 3, 1);
    hif.dmem_ready = 1'b1;
    step("mw_ready", 4'b1111, 3'b000, 2'b00, 2'b00, 4, 1);
    clr();
    step("mw_after", 4'b1111, 3'b000, 2'b00, 2'b00, 4, 1);
    hif.dmem_req = 1'b1; hif.dmem_ready = 1'b1;
    step("req_ready", 4'b1111, 3'b000, 2'b00, 2'b00, 4, 1);

    clr(); hif.ex_redirect = 1'b1; hif.dmem_req = 1'b1;
    step("wr_0", 4'b0000, 3'b001, 2'b00, 2'b00, 4, 1);
    step("wr_1", 4'b0000, 3'b001, 2'b00, 2'b00, 5, 1);
    hif.dmem_ready = 1'b1;
    step("wr_ready", 4'b1111, 3'b110, 2'b00, 2'b00, 6, 1);
    clr();
    step("wr_redir", 4'b1111, 3'b100, 2'b00, 2'b00, 6, 2);
    step("wr_run", 4'b1111, 3'b000, 2'b00, 2'b00, 6, 2);

    hif.ex_redirect = 1'b1;
    step("rm_redir", 4'b1111, 3'b110, 2'b00, 2'b00, 6, 2);
    clr(); hif.dmem_req = 1'b1;
    step("rm_miss", 4'b0000, 3'b001, 2'b00, 2'b00, 6, 3);
    hif.dmem_ready = 1'b1;
    step("rm_pend", 4'b1111, 3'b100, 2'b00, 2'b00, 7, 3);
    clr();
    step("rm_run", 4'b1111, 3'b000, 2'b00, 2'b00, 7, 3);

    hif.ex_redirect = 1'b1;
    step("rl_redir", 4'b1111, 3'b110, 2'b00, 2'b00, 7, 3);
    clr(); hif.ex_memread = 1'b1; hif.ex_rd = 5'd7; hif.id_rs1 = 5'd7; hif.id_use_rs1 = 1'b1;
    step("rl_lu", 4'b0011, 3'b110, 2'b00, 2'b00, 7, 4);
    clr();
    step("rl_run", 4'b1111, 3'b000, 2'b00, 2'b00, 8, 4);

    hif.dmem_req = 1'b1;
    step("rst_mw", 4'b0000, 3'b001, 2'b00, 2'b00, 8, 4);
    rst = 1'b1; hif.ex_rs1 = 5'd5; hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
    step("rst_mid", 4'b0000, 3'b111, 2'b00, 2'b00, -1, -1);
    rst = 1'b0; clr();
    step("rst_after", 4'b1111, 3'b000, 2'b00, 2'b00, 0, 0);

    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    vectors++;
    if (sif.stall_cycles !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_stall: got %0d want 15", sif.stall_cycles);
    end
    vectors++;
    if (sif.redirects !== 4'd0) begin
      miscompares++;
      $display("FAIL sat_redirects: got %0d want 0", sif.redirects);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
